// File: rtl/cont_pkg.sv
// Shared encodings and helpers for the parametrised up/down counter.
package cont_pkg;

    localparam logic CNT_DIR_UP    = 1'b1;
    localparam logic CNT_DIR_DOWN  = 1'b0;
    localparam logic CNT_MODE_WRAP = 1'b0;
    localparam logic CNT_MODE_SAT  = 1'b1;

    // 32-bit so one definition serves every WIDTH; callers truncate the result back.
    function automatic logic [31:0] clamp_to_mod(input logic [31:0] v, input logic [31:0] m);
        return (v > m) ? m : v;
    endfunction

endpackage

// File: rtl/cont_updown_mod_if.sv
// Control/status bundle of cont_updown_mod; the counter is the slave, its driver the master.
interface cont_updown_mod_if #(
    parameter int WIDTH   = 4,
    parameter int PRESC_W = 4
);
    logic               enable;
    logic               updown;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic [WIDTH-1:0]   mod_val;
    logic               sat_mode;
    logic [PRESC_W-1:0] presc_div;
    logic [WIDTH-1:0]   Q;
    logic               TC;
    logic               wrap;

    modport master (
        output enable, updown, load, load_val, mod_val, sat_mode, presc_div,
        input  Q, TC, wrap
    );

    modport slave (
        input  enable, updown, load, load_val, mod_val, sat_mode, presc_div,
        output Q, TC, wrap
    );
endinterface

// File: rtl/cont_updown_mod_prescaler.sv
// Enable-gated prescaler counting 0..presc_div; built only when CNT_PRESCALER_EN is defined.
`ifdef CNT_PRESCALER_EN
module cont_prescaler #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               enable_i,
    input  logic [PRESC_W-1:0] presc_div_i,
    output logic               presc_tick_o
);
    logic [PRESC_W-1:0] presc_q, presc_d;

    assign presc_tick_o = enable_i & (presc_q == presc_div_i);

    always_comb begin
        presc_d = presc_q;
        if (load_i)
            presc_d = '0;
        else if (presc_tick_o)
            presc_d = '0;
        else if (enable_i)
            presc_d = presc_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) presc_q <= '0;
        else       presc_q <= presc_d;
    end
endmodule
`endif

// File: rtl/cont_updown_mod.sv
// Parametrised up/down counter: programmable modulus, load, wrap/saturate, TC and wrap pulse.
// Optional prescaler on the count tick when CNT_PRESCALER_EN is defined.
module cont_updown_mod
    import cont_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int RST_VAL = 0,
    parameter int PRESC_W = 4
) (
    input logic              clk,
    input logic              reset,
    cont_updown_mod_if.slave bus
);
    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             ce;
    logic             at_end;
    logic             up;
    logic             sat;

`ifdef CNT_PRESCALER_EN
    logic presc_tick;

    cont_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk          (clk),
        .reset        (reset),
        .load_i       (bus.load),
        .enable_i     (bus.enable),
        .presc_div_i  (bus.presc_div),
        .presc_tick_o (presc_tick)
    );
    assign ce = bus.enable & presc_tick;
`else
    logic unused_presc;
    assign unused_presc = ^bus.presc_div;
    assign ce           = bus.enable;
`endif

    assign up     = (bus.updown == CNT_DIR_UP);
    assign sat    = (bus.sat_mode == CNT_MODE_SAT);
    assign at_end = up ? (q_q >= bus.mod_val) : (q_q == '0);

    // TC ignores the prescaler so cascaded stages behave like the original 4-bit block.
    assign bus.TC   = bus.enable & at_end;
    assign bus.Q    = q_q;
    assign bus.wrap = wrap_q;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            q_d = WIDTH'(clamp_to_mod(32'(bus.load_val), 32'(bus.mod_val)));
        end else if (ce) begin
            if (up) begin
                if (q_q < bus.mod_val) begin
                    q_d = q_q + 1'b1;
                end else if (sat) begin
                    q_d = bus.mod_val;
                end else begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                // Above a freshly lowered modulus: snap down without a wrap.
                if (q_q > bus.mod_val) begin
                    q_d = bus.mod_val;
                end else if (q_q != '0) begin
                    q_d = q_q - 1'b1;
                end else if (!sat) begin
                    q_d    = bus.mod_val;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= WIDTH'(RST_VAL);
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end
endmodule

// File: tb/tb_cont_updown_mod.sv
// Scoreboard bench for cont_updown_mod: expectations queued at drive time, popped after each edge.
module tb_cont_updown_mod;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cont_updown_mod_if #(.WIDTH(4), .PRESC_W(4)) b  ();
    cont_updown_mod_if #(.WIDTH(4), .PRESC_W(4)) bl ();
    cont_updown_mod_if #(.WIDTH(4), .PRESC_W(4)) bh ();

    cont_updown_mod #(.WIDTH(4), .RST_VAL(0), .PRESC_W(4)) dut    (.clk(clk), .reset(rst), .bus(b));
    cont_updown_mod #(.WIDTH(4), .RST_VAL(0), .PRESC_W(4)) dut_lo (.clk(clk), .reset(rst), .bus(bl));
    cont_updown_mod #(.WIDTH(4), .RST_VAL(0), .PRESC_W(4)) dut_hi (.clk(clk), .reset(rst), .bus(bh));

    assign bh.enable = bl.TC;

    typedef struct { logic [3:0] q; logic w; } exp_t;
    typedef struct {
        logic rs; logic ld; logic [3:0] lv; logic [3:0] md;
        logic up; logic sat; logic en; logic tc; logic [3:0] q; logic w;
    } row_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic test_reset();
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        b.enable = 0; b.updown = 1; b.load = 0; b.load_val = 0; b.mod_val = 9; b.sat_mode = 0; b.presc_div = 0;
        bl.updown = 1; bl.load = 0; bl.load_val = 0; bl.mod_val = 15; bl.sat_mode = 0; bl.presc_div = 0; bl.enable = 0;
        bh.updown = 1; bh.load = 0; bh.load_val = 0; bh.mod_val = 15; bh.sat_mode = 0; bh.presc_div = 0;
        sbq.push_back('{4'd0, 1'b0});
        @(posedge clk); #1;
        e = sbq.pop_front();
        checks++;
        if (b.Q !== e.q || b.wrap !== e.w || b.TC !== 1'b0) begin
            errors++;
            $display("FAIL reset Q=%0d wrap=%0b TC=%0b expected Q=%0d wrap=%0b TC=0", b.Q, b.wrap, b.TC, e.q, e.w);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wrap_up();
        exp_t e;
        int cur = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            b.enable = 1; b.updown = 1; b.sat_mode = 0; b.mod_val = 9; b.load = 0;
            #1;
            checks++;
            if (b.TC !== (cur == 9)) begin
                errors++;
                $display("FAIL wrap_up_tc[%0d] TC=%0b expected %0b (Q=%0d)", i, b.TC, (cur == 9), cur);
            end
            sbq.push_back('{(cur == 9) ? 4'd0 : 4'(cur + 1), (cur == 9)});
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if (b.Q !== e.q || b.wrap !== e.w) begin
                errors++;
                $display("FAIL wrap_up[%0d] Q=%0d wrap=%0b expected Q=%0d wrap=%0b", i, b.Q, b.wrap, e.q, e.w);
            end
            cur = (cur == 9) ? 0 : cur + 1;
        end
    endtask

    task automatic run_table(input string nm, input row_t rows[$]);
        exp_t e;
        for (int i = 0; i < rows.size(); i++) begin
            @(negedge clk);
            rst = rows[i].rs; b.load = rows[i].ld; b.load_val = rows[i].lv; b.mod_val = rows[i].md;
            b.updown = rows[i].up; b.sat_mode = rows[i].sat; b.enable = rows[i].en;
            #1;
            checks++;
            if (b.TC !== rows[i].tc) begin
                errors++;
                $display("FAIL %s_tc[%0d] TC=%0b expected %0b", nm, i, b.TC, rows[i].tc);
            end
            sbq.push_back('{rows[i].q, rows[i].w});
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if (b.Q !== e.q || b.wrap !== e.w) begin
                errors++;
                $display("FAIL %s[%0d] Q=%0d wrap=%0b expected Q=%0d wrap=%0b", nm, i, b.Q, b.wrap, e.q, e.w);
            end
        end
        @(negedge clk);
        rst = 0; b.load = 0; b.enable = 0;
    endtask

    task automatic test_down();
        row_t r[$];
        //          rs ld lv md up sat en  tc  q   w
        r.push_back('{0, 1, 0, 9, 0, 0, 0, 0, 0, 0});
        r.push_back('{0, 0, 0, 9, 0, 0, 1, 1, 9, 1});
        r.push_back('{0, 0, 0, 9, 0, 0, 1, 0, 8, 0});
        r.push_back('{0, 1, 0, 9, 0, 0, 0, 0, 0, 0});
        r.push_back('{0, 0, 0, 9, 0, 1, 1, 1, 0, 0});
        r.push_back('{0, 0, 0, 9, 0, 1, 1, 1, 0, 0});
        run_table("down", r);
    endtask

    task automatic test_load();
        row_t r[$];
        r.push_back('{0, 1, 12, 9,  1, 0, 1, 0, 9,  0});
        r.push_back('{0, 1, 4,  9,  1, 0, 1, 1, 4,  0});
        r.push_back('{0, 1, 15, 15, 1, 0, 0, 0, 15, 0});
        r.push_back('{1, 1, 7,  9,  1, 0, 1, 1, 0,  0});
        r.push_back('{0, 0, 0,  9,  1, 0, 0, 0, 0,  0});
        r.push_back('{0, 1, 9,  9,  1, 0, 0, 0, 9,  0});
        r.push_back('{1, 0, 0,  9,  1, 0, 1, 1, 0,  0});
        run_table("load", r);
    endtask

    task automatic test_mod_change();
        row_t r[$];
        r.push_back('{0, 1, 8, 9, 1, 0, 0, 0, 8, 0});
        r.push_back('{0, 0, 0, 5, 1, 0, 1, 1, 0, 1});
        r.push_back('{0, 1, 8, 9, 1, 0, 0, 0, 8, 0});
        r.push_back('{0, 0, 0, 5, 1, 1, 1, 1, 5, 0});
        r.push_back('{0, 1, 8, 9, 1, 0, 0, 0, 8, 0});
        r.push_back('{0, 0, 0, 5, 0, 0, 1, 0, 5, 0});
        r.push_back('{0, 0, 0, 0, 1, 0, 1, 1, 0, 1});
        r.push_back('{0, 0, 0, 0, 1, 0, 1, 1, 0, 1});
        r.push_back('{0, 0, 0, 0, 1, 0, 0, 0, 0, 0});
        r.push_back('{0, 0, 0, 0, 0, 0, 1, 1, 0, 1});
        run_table("modchg", r);
    endtask

    task automatic test_cascade();
        exp_t e;
        int hi_wraps = 0;
        int lo_wraps = 0;
        @(negedge clk);
        rst = 1; bl.enable = 0;
        @(negedge clk);
        rst = 0; bl.enable = 1;
        sbq.push_back('{4'd1, 1'b0});
        sbq.push_back('{4'd1, 1'b0});
        sbq.push_back('{4'd0, 1'b1});
        sbq.push_back('{4'd0, 1'b1});
        for (int i = 1; i <= 256; i++) begin
            @(posedge clk); #1;
            if (bh.wrap) hi_wraps++;
            if (bl.wrap) lo_wraps++;
            if (i == 17 || i == 256) begin
                e = sbq.pop_front();
                checks++;
                if (bl.Q !== e.q || bl.wrap !== e.w) begin
                    errors++;
                    $display("FAIL cascade_lo@%0d Q=%0d wrap=%0b expected Q=%0d wrap=%0b", i, bl.Q, bl.wrap, e.q, e.w);
                end
                e = sbq.pop_front();
                checks++;
                if (bh.Q !== e.q || bh.wrap !== e.w) begin
                    errors++;
                    $display("FAIL cascade_hi@%0d Q=%0d wrap=%0b expected Q=%0d wrap=%0b", i, bh.Q, bh.wrap, e.q, e.w);
                end
            end
        end
        @(negedge clk);
        bl.enable = 0;
        checks++;
        if (hi_wraps !== 1 || lo_wraps !== 16) begin
            errors++;
            $display("FAIL cascade_wraps hi=%0d lo=%0d expected hi=1 lo=16", hi_wraps, lo_wraps);
        end
    endtask

`ifdef CNT_PRESCALER_EN
    task automatic test_prescaler();
        exp_t e;
        int q = 0;
        int pr = 0;
        int div;
        for (int ph = 0; ph < 4; ph++) begin
            div = (ph == 3) ? 0 : 3;
            if (ph == 0 || ph == 3) begin
                @(negedge clk);
                b.load = 1; b.load_val = 0; b.mod_val = 15; b.updown = 1; b.sat_mode = 0;
                b.enable = 0; b.presc_div = 4'(div);
                @(posedge clk); #1;
                q = 0; pr = 0;
            end
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                b.load = 0; b.enable = (ph != 1);
                if (ph != 1) begin
                    if (pr == div) begin pr = 0; q++; end
                    else pr++;
                end
                sbq.push_back('{4'(q), 1'b0});
                @(posedge clk); #1;
                e = sbq.pop_front();
                checks++;
                if (b.Q !== e.q || b.wrap !== e.w) begin
                    errors++;
                    $display("FAIL presc[%0d.%0d] Q=%0d wrap=%0b expected Q=%0d wrap=%0b", ph, i, b.Q, b.wrap, e.q, e.w);
                end
            end
        end
        @(negedge clk);
        b.enable = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_wrap_up();
        test_down();
        test_load();
        test_mod_change();
        test_cascade();
`ifdef CNT_PRESCALER_EN
        test_prescaler();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cont_updown_mod.md
Name: cont_updown_mod

Overview:
Parametrised successor to the team's 4-bit up/down counter. Adds:
- generic width
- runtime-programmable modulus
- synchronous load
- wrap or saturate mode
- bidirectional terminal count
- registered wrap pulse

Used as a timebase or event counter in lab designs. The TC output supports cascading, by feeding one stage's TC into the next stage's enable.

Parameters:
WIDTH, 4, counter width in bits (legal range 2..32)
RST_VAL, 0, value Q takes on reset (must be <= 2^WIDTH-1)
PRESC_W, 4, prescaler width (used only with CNT_PRESCALER_EN)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous reset, active-high
enable  in  1  count enable (cascade input)
updown  in  1  1 = count up, 0 = count down
load  in  1  synchronous load strobe
load_val  in  WIDTH  value loaded when load=1
mod_val  in  WIDTH  terminal (maximum) count; counting range is 0..mod_val
sat_mode  in  1  1 = saturate at the ends, 0 = wrap
presc_div  in  PRESC_W  prescale divide-1 (ignored unless the macro is defined)
Q  out  WIDTH  registered count
TC  out  1  combinational terminal count, qualified by enable
wrap  out  1  registered one-cycle pulse, asserted after a wrap occurs

Behaviour:
- All state updates on the rising edge of clk.
- Priority: reset > load > enable > hold.
- Reset, sampled at the edge:
  - Q <= RST_VAL
  - wrap <= 0
  - prescaler <= 0
  - Reset in mid-count aborts the count immediately; there is no pending wrap.
- Load:
  - Q <= min(load_val, mod_val), so an out-of-range load clamps to mod_val.
  - wrap <= 0.
  - Load overrides enable in the same cycle.
- Internal count tick (ce): ce = enable when the macro is absent; ce = enable & presc_tick when present.
- Terminal condition ("at_end"):
  - Up: Q >= mod_val.
  - Down: Q == 0.
- TC = enable & at_end.
  - Combinational, zero latency.
  - Not gated by the prescaler, so cascades see the same TC as in the 4-bit block.
- Counting up on ce:
  - Q < mod_val: Q <= Q+1.
  - at_end with sat_mode=1: Q <= mod_val and wrap <= 0. Note that Q > mod_val also collapses to mod_val.
  - at_end with sat_mode=0: Q <= 0 and wrap <= 1.
- Counting down on ce:
  - Q > mod_val: Q <= mod_val. This handles a modulus lowered at runtime, and is not a wrap.
  - Otherwise, Q > 0: Q <= Q-1.
  - Q == 0 with sat_mode=1: Q holds 0 and wrap <= 0.
  - Q == 0 with sat_mode=0: Q <= mod_val and wrap <= 1.
- Hold: when there is no ce and no load, Q holds and wrap <= 0. wrap is never high for two consecutive cycles unless two wraps occur in consecutive cycles.
- mod_val == 0: Q stays at 0. In wrap mode every ce asserts wrap; TC = enable.
- mod_val may change at any time; it takes effect at the next edge. There is no shadow register.
- updown may change on any cycle. Direction is sampled with ce at the same edge.
- Arithmetic:
  - Computed in WIDTH bits.
  - No overflow past 2^WIDTH-1 is possible, because mod_val <= 2^WIDTH-1.

Optional Feature:
Macro: CNT_PRESCALER_EN
- Defined:
  - Adds a PRESC_W-bit prescaler counting 0..presc_div, advancing only while enable=1.
  - presc_tick = enable & (presc == presc_div).
  - On presc_tick the prescaler returns to 0.
  - load clears the prescaler.
  - presc_div = 0 behaves as the undivided counter.
- Undefined:
  - No prescaler logic is built.
  - presc_div remains a port but is ignored.
  - ce = enable.

Decomposition:
- Package cont_pkg: mode encodings (CNT_DIR_UP=1, CNT_DIR_DOWN=0, CNT_MODE_WRAP=0, CNT_MODE_SAT=1) and a function clamp_to_mod().
- One natural sub-module, cont_prescaler (PRESC_W). It is instantiated only under CNT_PRESCALER_EN and outputs presc_tick.
- The main counter stays in cont_updown_mod.

Test Plan:
1. WIDTH=4, mod_val=9, wrap mode, up, enable=1 for 12 cycles from reset → Q sequence 0..9,0,1. TC=1 only while Q=9. wrap=1 exactly in the cycle after Q 9→0.
2. Down, wrap mode, mod_val=9, Q=0 → next Q=9, wrap pulses. Then sat_mode=1 at Q=0 → Q holds 0, wrap=0, TC=1.
3. load=1, load_val=12, mod_val=9 → Q=9. Load plus enable in the same cycle → load wins. Reset plus load in the same cycle → Q=RST_VAL.
4. Q=8, change mod_val to 5, count up → Q=0 plus wrap (wrap mode) or Q=5 (sat mode). Count down from Q=8 → Q=5, no wrap.
5. Cascade two 4-bit instances, mod_val=15, wrap mode: the low stage's TC drives the high stage's enable. After 256 enabled cycles from 0 → both stages read 0, and the high stage's wrap has pulsed once.
6. With CNT_PRESCALER_EN, presc_div=3, up → Q increments every 4th enabled cycle. Dropping enable freezes both the prescaler and Q. presc_div=0 → increments every cycle.
